// File: rtl/seg_arbiter.sv
// seg_arbiter: three requesters share one multiplexed 8-digit, 7-segment display.
// A scan counter steps through the digit slots. Ownership of the display can only
// change at a frame boundary, and a newly granted owner holds the display for a
// minimum number of frames before a higher-priority requester can take it.
//
// Ports:
//   clk                  system clock (rising edge)
//   rst                  synchronous reset, active low
//   req0..req2           display requests; priority 2 > 1 > 0
//   dig0..dig2           eight BCD-ish nibbles, [31:28] = leftmost digit
//   blank0..blank2       per-digit force-off, bit7 = leftmost
//   blink0..blink2       per-digit blink enable, bit7 = leftmost
//   grant                one-hot owner, 3'b000 = idle
//   seg_data             segment code {a,b,c,d,e,f,g,dp}, active high
//   seg_which            digit select, active high, bit7 = leftmost
module seg_arbiter #(
   parameter int SCAN_DIV    = 200000,
   parameter int HOLD_FRAMES = 50,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        req2,
   input  logic [31:0] dig0,
   input  logic [31:0] dig1,
   input  logic [31:0] dig2,
   input  logic [7:0]  blank0,
   input  logic [7:0]  blank1,
   input  logic [7:0]  blank2,
   input  logic [7:0]  blink0,
   input  logic [7:0]  blink1,
   input  logic [7:0]  blink2,
   output logic [2:0]  grant,
   output logic [7:0]  seg_data,
   output logic [7:0]  seg_which
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam int HW = $clog2(HOLD_FRAMES + 1);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [2:0]     idx;
   logic [BW-1:0]  blink_cnt;
   logic           blink_phase;
   logic [HW-1:0]  hold_cnt;

   function automatic logic [2:0] pick(input logic [2:0] r);
      if (r[2])      return 3'b100;
      else if (r[1]) return 3'b010;
      else if (r[0]) return 3'b001;
      else           return 3'b000;
   endfunction

   function automatic logic [7:0] decode(input logic [3:0] n);
      case (n)
         4'h0: return 8'hFC;
         4'h1: return 8'h60;
         4'h2: return 8'hDA;
         4'h3: return 8'hF2;
         4'h4: return 8'h66;
         4'h5: return 8'hB6;
         4'h6: return 8'hBE;
         4'h7: return 8'hE0;
         4'h8: return 8'hFE;
         4'h9: return 8'hF6;
         4'hA: return 8'h02;
         default: return 8'h00;
      endcase
   endfunction

   logic [2:0]    req_v, top, nxt_grant, disp_idx;
   logic [HW-1:0] nxt_hold;
   logic [CW-1:0] count_nxt;
   logic          tick, boundary, suppress;
   logic [31:0]   sel_dig;
   logic [7:0]    sel_blank, sel_blink, disp_data, disp_which;
   logic [3:0]    nib;

   always_comb begin
      req_v     = {req2, req1, req0};
      top       = pick(req_v);
      tick      = (count == CW'(SCAN_DIV - 1));
      boundary  = tick && (idx == 3'd7);
      count_nxt = tick ? '0 : count + 1'b1;
      nxt_grant = grant;
      nxt_hold  = hold_cnt;
      disp_idx  = idx + 3'd1;
      if (state == IDLE) begin
         disp_idx = 3'd0;
         if (|req_v) begin
            nxt_grant = top;
            nxt_hold  = HW'(HOLD_FRAMES - 1);
         end
      end else if (boundary) begin
         // Owner released: take whoever is waiting, hold does not apply.
         // Owner still requesting: only a higher-priority request with an
         // expired hold may preempt. One-hot compare doubles as priority.
         if ((req_v & grant) == 3'b000)
            nxt_grant = top;
         else if (top > grant && hold_cnt == '0)
            nxt_grant = top;
         if (nxt_grant != grant)
            nxt_hold = (nxt_grant != 3'b000) ? HW'(HOLD_FRAMES - 1) : '0;
         else if (hold_cnt != '0)
            nxt_hold = hold_cnt - 1'b1;
      end

      case (nxt_grant)
         3'b100:  begin sel_dig = dig2; sel_blank = blank2; sel_blink = blink2; end
         3'b010:  begin sel_dig = dig1; sel_blank = blank1; sel_blink = blink1; end
         default: begin sel_dig = dig0; sel_blank = blank0; sel_blink = blink0; end
      endcase

      // Slot idx maps to nibble/bit 7-idx, i.e. ~idx for a 3-bit index.
      nib        = sel_dig[{~disp_idx, 2'b00} +: 4];
      suppress   = (nxt_grant == 3'b000) || sel_blank[~disp_idx] ||
                   (sel_blink[~disp_idx] && blink_phase);
      disp_which = suppress ? 8'h00 : (8'h80 >> disp_idx);
      disp_data  = suppress ? 8'h00 : decode(nib);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         idx         <= 3'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         hold_cnt    <= '0;
         grant       <= 3'b000;
         seg_data    <= 8'h00;
         seg_which   <= 8'h00;
      end else begin
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (|req_v) begin
                  // Restart the scan so the new owner starts on a clean frame.
                  state     <= OWNED;
                  count     <= '0;
                  idx       <= 3'd0;
                  grant     <= nxt_grant;
                  hold_cnt  <= nxt_hold;
                  seg_data  <= disp_data;
                  seg_which <= disp_which;
               end else begin
                  count <= count_nxt;
                  if (tick) idx <= idx + 3'd1;
               end
            end
            OWNED: begin
               count <= count_nxt;
               if (tick) begin
                  idx       <= disp_idx;
                  grant     <= nxt_grant;
                  hold_cnt  <= nxt_hold;
                  seg_data  <= disp_data;
                  seg_which <= disp_which;
                  if (nxt_grant == 3'b000) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 200000, clk cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter HOLD_FRAMES, default 50, minimum frames a new grant is held against preemption (minimum 1).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink phase toggle.
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req0/req1/req2  in  1 each  display request from requester n.
REQ-007 SHALL have ports dig0/dig1/dig2  in  32 each  eight nibbles; [31:28] = leftmost digit, [3:0] = rightmost.
REQ-008 SHALL have ports blank0/blank1/blank2  in  8 each  per-digit force-off; bit7 = leftmost.
REQ-009 SHALL have ports blink0/blink1/blink2  in  8 each  per-digit blink enable; bit7 = leftmost.
REQ-010 SHALL have port grant  out  3  one-hot owner; 3'b000 = idle.
REQ-011 SHALL have port seg_data  out  8  segment code {a,b,c,d,e,f,g,dp}, active-high.
REQ-012 SHALL have port seg_which  out  8  digit select, active-high; bit7 = leftmost.

Function
REQ-013 SHALL count scan cycles 0..SCAN_DIV-1; tick = count at SCAN_DIV-1, then wrap to 0.
REQ-014 SHALL advance a 3-bit digit index idx on each tick, 7 wraps to 0; frame boundary = tick with idx==7.
REQ-015 SHALL register all outputs; on each tick, seg_which/seg_data take the value for the new idx, in the same edge that idx changes.
REQ-016 SHALL set seg_which = 8'b1000_0000 >> idx, unless the digit is suppressed, in which case seg_which = 0.
REQ-017 SHALL suppress a digit when grant==0, or its blank bit is set, or its blink bit is set while blink phase==1.
REQ-018 SHALL decode the nibble as: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex), A=02 ('-'), B..F=00.
REQ-019 SHALL toggle blink phase every BLINK_DIV cycles, free-running.
REQ-020 SHALL have arbitration states IDLE (grant 0) and OWNED.
REQ-021 IDLE: on any req, SHALL grant the highest-priority requester (2>1>0) at the next edge, force count=0 and idx=0, and output digit 0 of the new owner at that same edge.
REQ-022 OWNED: SHALL re-arbitrate only at frame boundaries; the new grant applies to the idx-0 output produced at that same edge.
REQ-023 At a frame boundary with the owner's req low: SHALL grant the highest pending requester, or go to IDLE with outputs 0 if none, regardless of hold.
REQ-024 At a frame boundary with the owner's req high: SHALL switch only to a higher-priority requester, and only when hold_cnt==0; lower-priority requesters never preempt.
REQ-025 SHALL load hold_cnt = HOLD_FRAMES-1 on every grant change to nonzero, and decrement it (saturating at 0) on each frame boundary without a change.
REQ-026 SHALL sample req/dig/blank/blink on the deciding edge; mid-frame input changes are visible on the next digit slot.
REQ-027 SHALL keep grant one-hot or zero at all times.

Reset
REQ-028 With rst==0 at an edge: count=0, idx=0, blink phase=0, hold_cnt=0, grant=0, seg_data=0, seg_which=0; this overrides any tick or request in that cycle.
REQ-029 After rst is released mid-frame, SHALL resume from IDLE; no partial frame of the prior owner is displayed.

Verification (SCAN_DIV=4, HOLD_FRAMES=2, BLINK_DIV=64)
REQ-030 Reset then req0=1, dig0=32'h1234_5678 -> grant=001 next edge, seg_which=80/seg_data=60, then 40/DA, 20/F2 ... 01/FE every 4 cycles.
REQ-031 Owner req0; req2 asserts mid-frame -> grant stays 001 until 2nd frame boundary after grant (hold), then 100 with idx 0.
REQ-032 Owner req2, req1 asserted -> grant stays 100; drop req2 -> grant=010 at next frame boundary; drop all -> grant=000, seg_which=0.
REQ-033 blank0=8'h24, blink0=8'h03, dig0 nibbles 2 and 5 = A -> slots 2/5 dark; slots 6/7 dark only during blink phase 1; '-' code 02 never shown.
REQ-034 rst low for one cycle during slot 5 with grant=001 -> all outputs 0 next edge; after release with req0 high, restart at idx 0.
